systolic_ctrl: RTL and testbench

SYSTOLIC_CTRL -- requirements
Module: systolic_ctrl

---
 rtl/systolic_pkg.sv | 9 +
 rtl/systolic_ctrl_if.sv | 35 +++
 rtl/systolic_delay.sv | 16 +
 rtl/systolic_ctrl.sv | 92 +++++++++
 tb/tb_systolic_ctrl.sv | 86 ++++++++
 5 files changed

// File: rtl/systolic_pkg.sv
// systolic_pkg: shared FSM states, default dimensions and result latency for the systolic array controller
package systolic_pkg;
    localparam int N_DEF = 4;
    localparam int KW_DEF = 8;
    typedef enum logic [2:0] {IDLE, LOAD_W, FEED, DRAIN, DONE} state_t;
    function automatic int res_lat(input int n);
        return 2 * n - 1;
    endfunction
endpackage

// File: rtl/systolic_ctrl_if.sv
// systolic_ctrl_if: job request, buffer read and result write signals of systolic_ctrl
// perf_cycles exists only when SYSTOLIC_CTRL_PERF_EN is defined
interface systolic_ctrl_if import systolic_pkg::*; #(
    parameter int N = N_DEF,
    parameter int KW = KW_DEF
) ();
    logic start;
    logic [KW-1:0] k_len;
    logic busy;
    logic done;
    logic control;
    logic wt_rd_en;
    logic [$clog2(N)-1:0] wt_rd_addr;
    logic data_rd_en;
    logic [KW-1:0] data_rd_addr;
    logic res_vld;
    logic [KW-1:0] res_addr;
`ifdef SYSTOLIC_CTRL_PERF_EN
    logic [31:0] perf_cycles;
`endif
    modport master (
        output start, k_len,
        input busy, done, control, wt_rd_en, wt_rd_addr, data_rd_en, data_rd_addr, res_vld, res_addr
`ifdef SYSTOLIC_CTRL_PERF_EN
        , perf_cycles
`endif
    );
    modport slave (
        input start, k_len,
        output busy, done, control, wt_rd_en, wt_rd_addr, data_rd_en, data_rd_addr, res_vld, res_addr
`ifdef SYSTOLIC_CTRL_PERF_EN
        , perf_cycles
`endif
    );
endinterface

// File: rtl/systolic_delay.sv
// systolic_delay: DEPTH-stage 1-bit shift register with synchronous reset
module systolic_delay #(
    parameter int DEPTH = 7
) (
    input logic clk,
    input logic rst,
    input logic d,
    output logic q
);
    logic [DEPTH-1:0] sr;
    always_ff @(posedge clk) begin
        if (rst) sr <= '0;
        else sr <= DEPTH'({sr, d});
    end
    assign q = sr[DEPTH-1];
endmodule

// File: rtl/systolic_ctrl.sv
// systolic_ctrl: sequences weight load, vector feed and drain of an NxN systolic array
// optional SYSTOLIC_CTRL_PERF_EN adds a busy-cycle counter for the last job
module systolic_ctrl import systolic_pkg::*; #(
    parameter int N = N_DEF,
    parameter int KW = KW_DEF
) (
    input logic clk,
    input logic rst,
    systolic_ctrl_if.slave bus
);
    localparam int RL = res_lat(N);
    localparam int DW = $clog2(RL + 1);
    localparam int AW = $clog2(N);
    state_t state;
    logic [KW-1:0] klen_q;
    logic [DW-1:0] dcnt;
    logic drain_last;
    assign drain_last = (state == DRAIN) && (dcnt == DW'(RL - 1));
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            klen_q <= '0;
            dcnt <= '0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
            bus.control <= 1'b0;
            bus.wt_rd_en <= 1'b0;
            bus.wt_rd_addr <= '0;
            bus.data_rd_en <= 1'b0;
            bus.data_rd_addr <= '0;
            bus.res_addr <= '0;
        end else begin
            bus.done <= 1'b0;
            bus.res_addr <= drain_last ? '0 : bus.res_vld ? bus.res_addr + KW'(1) : bus.res_addr;
            case (state)
                IDLE: if (bus.start) begin
                    bus.busy <= 1'b1;
                    if (bus.k_len == '0) begin
                        state <= DONE;
                        bus.done <= 1'b1;
                    end else begin
                        state <= LOAD_W;
                        klen_q <= bus.k_len;
                        bus.control <= 1'b1;
                        bus.wt_rd_en <= 1'b1;
                        bus.wt_rd_addr <= AW'(N - 1);
                    end
                end
                // weights are pushed bottom row first so row 0 ends up nearest the inputs
                LOAD_W: if (bus.wt_rd_addr == '0) begin
                    state <= FEED;
                    bus.control <= 1'b0;
                    bus.wt_rd_en <= 1'b0;
                    bus.data_rd_en <= 1'b1;
                    bus.data_rd_addr <= '0;
                end else begin
                    bus.wt_rd_addr <= bus.wt_rd_addr - AW'(1);
                end
                FEED: if (bus.data_rd_addr == klen_q - KW'(1)) begin
                    state <= DRAIN;
                    bus.data_rd_en <= 1'b0;
                    dcnt <= '0;
                end else begin
                    bus.data_rd_addr <= bus.data_rd_addr + KW'(1);
                end
                DRAIN: if (drain_last) begin
                    state <= DONE;
                    bus.done <= 1'b1;
                end else begin
                    dcnt <= dcnt + DW'(1);
                end
                DONE: begin
                    state <= IDLE;
                    bus.busy <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
    systolic_delay #(.DEPTH(RL)) u_delay (
        .clk(clk),
        .rst(rst),
        .d(bus.data_rd_en),
        .q(bus.res_vld)
    );
`ifdef SYSTOLIC_CTRL_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) bus.perf_cycles <= '0;
        else bus.perf_cycles <= (state == IDLE && bus.start) ? '0 : bus.busy ? bus.perf_cycles + 32'd1 : bus.perf_cycles;
    end
`endif
endmodule

// File: tb/tb_systolic_ctrl.sv
// tb_systolic_ctrl: directed checks of systolic_ctrl job timing, start filtering, reset abort and long jobs
module tb_systolic_ctrl;
    localparam int N = 4;
    localparam int KW = 8;
    localparam int RL = 7;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_chk = 0;
    int n_fail = 0;
    always #5 clk = ~clk;
    systolic_ctrl_if #(.N(N), .KW(KW)) bus ();
    systolic_ctrl #(.N(N), .KW(KW)) dut (.clk(clk), .rst(rst), .bus(bus));

    task automatic chk(input string tag, input int c, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s cycle %0d: got %0d expected %0d", tag, c, got, exp);
        end
    endtask

    // start is raised now (cycle 0); every cycle after it is checked against the expected schedule
    task automatic job(input int k, input int restart, input int rst_at, input int tail);
        int last;
        bit live, lw, fd, rv;
        last = (k == 0) ? 1 : N + k + RL + 1;
        bus.start = 1'b1;
        bus.k_len = KW'(k);
        for (int c = 1; c <= last + tail; c++) begin
            @(negedge clk);
            live = !(rst_at > 0 && c > rst_at);
            lw = live && k > 0 && c <= N;
            fd = live && k > 0 && c > N && c <= N + k;
            rv = live && k > 0 && c > N + RL && c <= N + k + RL;
            chk("busy", c, 32'(bus.busy), 32'(live && c <= last));
            chk("done", c, 32'(bus.done), 32'(live && c == last));
            chk("control", c, 32'(bus.control), 32'(lw));
            chk("wt_rd_en", c, 32'(bus.wt_rd_en), 32'(lw));
            chk("data_rd_en", c, 32'(bus.data_rd_en), 32'(fd));
            chk("res_vld", c, 32'(bus.res_vld), 32'(rv));
            if (lw) chk("wt_rd_addr", c, 32'(bus.wt_rd_addr), 32'(N - c));
            if (fd) chk("data_rd_addr", c, 32'(bus.data_rd_addr), 32'(c - N - 1));
            if (rv) chk("res_addr", c, 32'(bus.res_addr), 32'(c - N - RL - 1));
            if (live && c == last) chk("res_addr_clr", c, 32'(bus.res_addr), 0);
            if (!live) begin
                chk("rst_wt_addr", c, 32'(bus.wt_rd_addr), 0);
                chk("rst_data_addr", c, 32'(bus.data_rd_addr), 0);
                chk("rst_res_addr", c, 32'(bus.res_addr), 0);
            end
`ifdef SYSTOLIC_CTRL_PERF_EN
            if (live && c > last) chk("perf_cycles", c, bus.perf_cycles, 32'(last));
            if (!live) chk("perf_rst", c, bus.perf_cycles, 0);
`endif
            bus.start = (c == restart);
            rst = (c == rst_at);
        end
        bus.start = 1'b0;
    endtask

    initial begin
        bus.start = 1'b0;
        bus.k_len = '0;
        repeat (2) @(negedge clk);
        chk("reset_busy", 0, 32'(bus.busy), 0);
        chk("reset_done", 0, 32'(bus.done), 0);
        chk("reset_control", 0, 32'(bus.control), 0);
        chk("reset_wt_rd_en", 0, 32'(bus.wt_rd_en), 0);
        chk("reset_data_rd_en", 0, 32'(bus.data_rd_en), 0);
        chk("reset_res_vld", 0, 32'(bus.res_vld), 0);
        chk("reset_res_addr", 0, 32'(bus.res_addr), 0);
        rst = 1'b0;
        @(negedge clk);
        job(3, 0, 0, 1);
        job(0, 0, 0, 1);
        job(3, 6, 0, 1);
        job(3, 10, 0, 1);
        job(3, 15, 0, 2);
        job(3, 0, 6, 12);
        job(3, 0, 0, 1);
        job(1, 0, 0, 1);
        job(2, 0, 0, 1);
        job(255, 0, 0, 2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
